ysyx_25060170_mem_arb: RTL and testbench

Two-master, one-slave memory arbiter that shares the single data-memory port between the IFU (fetch, read-only) and the LSU (load/store).
- Sits between those stages and the memory back-end, replacing the separate per-stage memory paths.
- Serialises one outstanding transaction at a time.
- Supports fixed-priority or round-robin grant.
- Silently drops fetch responses killed by a pipeline flush.

---
 rtl/ysyx_25060170_mem_arb_pkg.sv | 8 +
 rtl/ysyx_25060170_mem_arb_pick.sv | 15 +
 rtl/ysyx_25060170_mem_arb.sv | 116 +++++++++++
 tb/tb_ysyx_25060170_mem_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060170_mem_arb_pkg.sv
// ysyx_25060170_mem_arb_pkg: shared widths, FSM states and owner encodings for the memory arbiter.
package ysyx_25060170_mem_arb_pkg;
    localparam int PC_W = 32;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;
endpackage

// File: rtl/ysyx_25060170_mem_arb_pick.sv
// ysyx_25060170_arb_pick: two-way request picker, fixed LS priority or round-robin against the last owner.
module ysyx_25060170_arb_pick
    import ysyx_25060170_mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       if_req_i,
    input  logic       ls_req_i,
    input  logic       last_owner_i,
    output logic [1:0] gnt_o
);
    // gnt_o[1] = LS, gnt_o[0] = IF; under RR the master that did not own last wins a conflict
    assign gnt_o[1] = ls_req_i & (~if_req_i | ~RR_EN | (last_owner_i == OWN_IF));
    assign gnt_o[0] = if_req_i & ~gnt_o[1];
endmodule

// File: rtl/ysyx_25060170_mem_arb.sv
// ysyx_25060170_mem_arb: shares one memory port between IFU and LSU, one outstanding transaction,
// dropping fetch responses that a flush killed while in flight.
module ysyx_25060170_mem_arb
    import ysyx_25060170_mem_arb_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DATA_W = XLEN,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    input  logic                if_kill,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_wen,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy,
    output logic                owner
);
    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d, drop_q, drop_d, wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic [1:0]          gnt;
    logic                in_idle, kill_own, resp_fire;

    ysyx_25060170_arb_pick #(.RR_EN(RR_EN)) u_pick (
        .if_req_i     (if_req_valid & ~if_kill),
        .ls_req_i     (ls_req_valid),
        .last_owner_i (owner_q),
        .gnt_o        (gnt)
    );

    // readys are gated by rst so nothing is accepted while reset is held
    assign in_idle   = (state_q == IDLE) & ~rst;
    assign kill_own  = if_kill & (owner_q == OWN_IF) & (state_q != IDLE);
    assign resp_fire = (state_q == WAIT) & mem_resp_valid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q | kill_own;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (in_idle && (|gnt)) begin
            state_d = ISSUE;
            owner_d = gnt[1];
            addr_d  = gnt[1] ? ls_req_addr : if_req_addr;
            wen_d   = gnt[1] & ls_req_wen;
            wdata_d = gnt[1] ? ls_req_wdata : '0;
            wmask_d = gnt[1] ? ls_req_wmask : '0;
        end else if (state_q == ISSUE && mem_req_ready) begin
            state_d = WAIT;
        end else if (resp_fire) begin
            state_d = IDLE;
            drop_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign if_req_ready  = in_idle & gnt[0];
    assign ls_req_ready  = in_idle & gnt[1];
    // a kill arriving in the same cycle as the response also suppresses it
    assign if_resp_valid = resp_fire & (owner_q == OWN_IF) & ~drop_q & ~if_kill;
    assign ls_resp_valid = resp_fire & (owner_q == OWN_LS);
    assign if_resp_data  = if_resp_valid ? mem_resp_data : '0;
    assign ls_resp_data  = ls_resp_valid ? mem_resp_data : '0;
    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign busy          = (state_q != IDLE);
    assign owner         = owner_q;

    assert property (@(posedge clk) disable iff (rst) !(state_q == ISSUE && mem_resp_valid));
endmodule

// File: tb/tb_ysyx_25060170_mem_arb.sv
// tb_ysyx_25060170_mem_arb: random IF/LS traffic against a transaction-level arbiter model,
// plus directed fetch, async reset and fixed-priority scenarios.
module tb_ysyx_25060170_mem_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 0, if_kill = 0, ls_req_valid = 0, ls_req_wen = 0;
    logic        mem_req_ready = 0, mem_resp_valid = 0;
    logic [31:0] if_req_addr = 0, ls_req_addr = 0, ls_req_wdata = 0, mem_resp_data = 0;
    logic [3:0]  ls_req_wmask = 0;
    logic        if_req_ready, if_resp_valid, ls_req_ready, ls_resp_valid;
    logic        mem_req_valid, mem_req_wen, busy, owner;
    logic [31:0] if_resp_data, ls_resp_data, mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        f_if_v = 0, f_ls_v = 0, f_mem_rdy = 0, f_resp_v = 0;
    logic        f_if_rdy, f_if_resp, f_ls_rdy, f_ls_resp, f_mem_v, f_mem_wen, f_busy, f_owner;
    logic [31:0] f_if_data, f_ls_data, f_mem_addr, f_mem_wdata;
    logic [3:0]  f_mem_wmask;
    int          checks = 0, failures = 0;
    bit          if_pend, ls_pend, m_busy, m_issued, m_drop, m_owner;
    int          m_delay;
    logic [31:0] e_addr, e_wd;
    logic        e_wen;
    logic [3:0]  e_wm;

    always #5 clk = ~clk;

    ysyx_25060170_mem_arb #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_kill(if_kill), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .owner(owner)
    );

    ysyx_25060170_mem_arb #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .if_req_valid(f_if_v), .if_req_ready(f_if_rdy), .if_req_addr(if_req_addr),
        .if_kill(1'b0), .if_resp_valid(f_if_resp), .if_resp_data(f_if_data),
        .ls_req_valid(f_ls_v), .ls_req_ready(f_ls_rdy), .ls_req_addr(ls_req_addr),
        .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_resp_valid(f_ls_resp), .ls_resp_data(f_ls_data),
        .mem_req_valid(f_mem_v), .mem_req_ready(f_mem_rdy), .mem_req_addr(f_mem_addr),
        .mem_req_wen(f_mem_wen), .mem_req_wdata(f_mem_wdata), .mem_req_wmask(f_mem_wmask),
        .mem_resp_valid(f_resp_v), .mem_resp_data(mem_resp_data),
        .busy(f_busy), .owner(f_owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // one cycle of random traffic; model state describes the transaction in flight, not the FSM
    task automatic step(input bit allow_new);
        bit ic, lc, g_if, g_ls, exp_if, exp_ls;
        @(negedge clk);
        if (allow_new && !if_pend && $urandom_range(0, 2) == 0) begin
            if_pend     = 1;
            if_req_addr = $urandom & ~32'h3;
        end
        if (allow_new && !ls_pend && $urandom_range(0, 2) == 0) begin
            ls_pend      = 1;
            ls_req_addr  = $urandom;
            ls_req_wen   = 1'($urandom_range(0, 1));
            ls_req_wdata = $urandom;
            ls_req_wmask = 4'($urandom);
        end
        if_req_valid   = if_pend;
        ls_req_valid   = ls_pend;
        if_kill        = allow_new && ($urandom_range(0, 5) == 0);
        mem_req_ready  = 1'($urandom_range(0, 1));
        mem_resp_valid = m_busy && m_issued && m_delay == 0;
        mem_resp_data  = $urandom;
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("owner", 32'(owner), 32'(m_owner));
        if (!m_busy) begin
            ic   = if_pend && !if_kill;
            lc   = ls_pend;
            g_ls = lc && (!ic || !m_owner);
            g_if = ic && !g_ls;
            check("if_req_ready", 32'(if_req_ready), 32'(g_if));
            check("ls_req_ready", 32'(ls_req_ready), 32'(g_ls));
            check("idle_mem_valid", 32'(mem_req_valid), 0);
            check("idle_resp", 32'({if_resp_valid, ls_resp_valid}), 0);
            if (g_if || g_ls) begin
                m_busy  = 1;
                m_owner = g_ls;
                e_addr  = g_ls ? ls_req_addr : if_req_addr;
                e_wen   = g_ls && ls_req_wen;
                e_wd    = g_ls ? ls_req_wdata : 32'h0;
                e_wm    = g_ls ? ls_req_wmask : 4'h0;
                if (g_ls) ls_pend = 0;
                else if_pend = 0;
            end
        end else begin
            check("busy_readys", 32'({if_req_ready, ls_req_ready}), 0);
            check("mem_req_valid", 32'(mem_req_valid), 32'(!m_issued));
            if (!m_owner && if_kill) m_drop = 1;
            if (!m_issued) begin
                check("mem_req_addr", mem_req_addr, e_addr);
                check("mem_req_wen", 32'(mem_req_wen), 32'(e_wen));
                check("mem_req_wdata", mem_req_wdata, e_wd);
                check("mem_req_wmask", 32'(mem_req_wmask), 32'(e_wm));
                check("issue_resp", 32'({if_resp_valid, ls_resp_valid}), 0);
                if (mem_req_ready) begin
                    m_issued = 1;
                    m_delay  = $urandom_range(0, 3);
                end
            end else begin
                exp_if = mem_resp_valid && !m_owner && !m_drop;
                exp_ls = mem_resp_valid && m_owner;
                check("if_resp_valid", 32'(if_resp_valid), 32'(exp_if));
                check("ls_resp_valid", 32'(ls_resp_valid), 32'(exp_ls));
                check("if_resp_data", if_resp_data, exp_if ? mem_resp_data : 32'h0);
                check("ls_resp_data", ls_resp_data, exp_ls ? mem_resp_data : 32'h0);
                if (mem_resp_valid) begin
                    m_busy   = 0;
                    m_issued = 0;
                    m_drop   = 0;
                end else m_delay--;
            end
        end
        if (if_kill) if_pend = 0;
    endtask

    initial begin
        int n;
        if_req_valid = 1;
        ls_req_valid = 1;
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_readys", 32'({if_req_ready, ls_req_ready}), 0);
        check("rst_mem_valid", 32'(mem_req_valid), 0);
        check("rst_resp", 32'({if_resp_valid, ls_resp_valid}), 0);
        @(negedge clk);
        rst = 0;
        if_req_valid = 0;
        ls_req_valid = 0;
        @(negedge clk);
        if_req_valid  = 1;
        if_req_addr   = 32'h8000_0000;
        mem_req_ready = 1;
        #1;
        check("t1_if_ready", 32'(if_req_ready), 1);
        check("t1_ls_ready", 32'(ls_req_ready), 0);
        @(negedge clk);
        if_req_valid = 0;
        #1;
        check("t1_mem_valid", 32'(mem_req_valid), 1);
        check("t1_mem_addr", mem_req_addr, 32'h8000_0000);
        check("t1_mem_wen", 32'(mem_req_wen), 0);
        @(negedge clk);
        mem_resp_valid = 1;
        mem_resp_data  = 32'h0000_0413;
        #1;
        check("t1_if_resp", 32'(if_resp_valid), 1);
        check("t1_if_data", if_resp_data, 32'h0000_0413);
        check("t1_ls_resp", 32'(ls_resp_valid), 0);
        @(negedge clk);
        mem_resp_valid = 0;
        #1;
        check("t1_busy", 32'(busy), 0);
        check("t1_if_resp_off", 32'(if_resp_valid), 0);
        m_owner = 0;
        repeat (3000) step(1);
        n = 0;
        while ((m_busy || if_pend || ls_pend) && n < 200) begin
            step(0);
            n++;
        end
        check("drain_timeout", 32'(m_busy || if_pend || ls_pend), 0);
        @(negedge clk);
        if_req_valid   = 1;
        if_req_addr    = 32'h8000_0010;
        ls_req_valid   = 0;
        if_kill        = 0;
        mem_req_ready  = 0;
        mem_resp_valid = 0;
        #1;
        check("ar_if_ready", 32'(if_req_ready), 1);
        @(negedge clk);
        #1;
        check("ar_mem_valid", 32'(mem_req_valid), 1);
        #2;
        rst = 1;
        #1;
        check("ar_mem_valid_rst", 32'(mem_req_valid), 0);
        check("ar_busy_rst", 32'(busy), 0);
        check("ar_addr_rst", mem_req_addr, 0);
        check("ar_owner_rst", 32'(owner), 0);
        check("ar_ready_rst", 32'(if_req_ready), 0);
        @(negedge clk);
        rst = 0;
        if_req_valid = 0;
        #1;
        check("ar_busy_after", 32'(busy), 0);
        check("ar_owner_after", 32'(owner), 0);
        @(negedge clk);
        f_if_v       = 1;
        f_ls_v       = 1;
        f_mem_rdy    = 1;
        if_req_addr  = 32'h8000_0004;
        ls_req_addr  = 32'h8000_1000;
        ls_req_wen   = 0;
        #1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            f_resp_v = (k % 3 == 2);
            #1;
            check("fix_if_ready", 32'(f_if_rdy), 0);
            check("fix_ls_ready", 32'(f_ls_rdy), 32'(k % 3 == 0));
            check("fix_mem_valid", 32'(f_mem_v), 32'(k % 3 == 1));
            if (k % 3 == 1) check("fix_mem_addr", f_mem_addr, 32'h8000_1000);
            check("fix_ls_resp", 32'(f_ls_resp), 32'(k % 3 == 2));
            check("fix_if_resp", 32'(f_if_resp), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
